serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
- Bit-serial sequential subtractor computing A - B - Bin, one bit per clock, LSB first.
- Uses a single full-subtractor cell with a registered borrow, replacing WIDTH parallel cells.
- Valid/ready on input and output sides.
- Sits on area-constrained datapaths where subtraction latency of WIDTH cycles is acceptable.

Parameters:
- WIDTH, 4, operand and difference width in bits (>= 2).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset; one clock; asynchronous, active-low.
- in_valid  input  1  operands present.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  minuend (unsigned).
- b  input  WIDTH  subtrahend (unsigned).
- bin  input  1  borrow-in.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- diff  output  WIDTH  difference.
- bout  output  1  borrow-out.
- ovf  output  1  signed overflow; present only with SERIAL_SUB_OVF_EN.

Behaviour:
- Arithmetic:
  - diff = (a - b - bin) mod 2^WIDTH.
  - bout = 1 iff a < b + bin (unsigned compare, no truncation of b + bin).
- Bit cell: d = x ^ y ^ br; br_next = (~x & y) | (~x & br) | (y & br).
- FSM states: S_IDLE, S_BUSY, S_DONE.
- S_IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: latch a, b into shift registers and bin into the borrow register; clear the bit counter; go to S_BUSY.
- S_BUSY:
  - in_ready = 0.
  - Each cycle: process LSBs, shift the result bit in at the diff MSB, update borrow, increment the counter.
  - After exactly WIDTH BUSY cycles, go to S_DONE.
- S_DONE:
  - out_valid = 1; diff and bout are stable.
  - On out_valid & out_ready, go to S_IDLE.
- Latency:
  - out_valid rises WIDTH clock edges after the accepting edge.
  - Throughput is one operation per WIDTH+2 cycles minimum. There is no overlap: in_ready is 1 only in S_IDLE.
- Handshake rules:
  - in_valid while in_ready = 0 is ignored; operands are not captured.
  - out_valid, diff and bout are held while out_ready = 0, indefinitely.
  - out_ready while out_valid = 0 has no effect.
- Output hold:
  - diff and bout are registered and change only during S_BUSY.
  - They retain the last result in S_IDLE.
  - They are meaningful only while out_valid = 1.
- Reset values (rst_n low, any state): state = S_IDLE, in_ready = 1, out_valid = 0, diff = 0, bout = 0, ovf = 0, counter = 0, internal shift registers = 0.
- Reset mid-operation: the partial result is discarded; after release, the block accepts fresh operands immediately.
- Counter is $clog2(WIDTH+1) bits wide; it never wraps within one operation.

Optional Feature:
- Macro: SERIAL_SUB_OVF_EN.
- Defined:
  - Port ovf exists, registered alongside bout.
  - ovf = (borrow into MSB) ^ (borrow out of MSB), i.e. two's-complement overflow of a - b - bin.
  - Reset 0; valid with out_valid.
- Undefined: no ovf port, no MSB-borrow capture register; all other behaviour is identical.

Decomposition:
- Package serial_sub_pkg: typedef enum logic [1:0] state_t {S_IDLE, S_BUSY, S_DONE}.
- Width-dependent constants (counter width) are module localparams derived from WIDTH.
- Sub-module full_subtractor (x, y, bin -> d, bout), purely combinational, instantiated once.

Test Plan:
- WIDTH=4: a=9, b=3, bin=0 accepted at edge N -> out_valid high after edge N+4, diff=6, bout=0.
- a=3, b=9, bin=0 -> diff=4'hA, bout=1; a=0, b=0, bin=1 -> diff=4'hF, bout=1 (wrap).
- Backpressure: out_ready held 0 for 5 cycles in S_DONE -> out_valid=1 and diff/bout unchanged throughout. A second in_valid pulse during BUSY/DONE is not captured (in_ready=0). After out_ready=1 for one cycle -> in_ready=1 next cycle.
- Reset: assert rst_n=0 after 2 BUSY cycles of a=12, b=5 -> out_valid=0, diff=0, bout=0, in_ready=1 immediately. After release, a=12, b=5 -> diff=7, bout=0.
- Back-to-back: in_valid held high with two operand sets -> both results correct, accepted operations separated by WIDTH+2 cycles minimum.
- SERIAL_SUB_OVF_EN: a=8 (-8), b=1 -> diff=7, ovf=1; a=7, b=1 -> diff=6, ovf=0; a=7, b=8 -> diff=15, ovf=1, bout=1.

Source files
------------

// File: rtl/serial_sub_pkg.sv
// Shared types for the bit-serial subtractor.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_subtractor.sv
// Single-bit full subtractor: d = x - y - bin, with borrow out.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~x & bin) | (y & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor computing a - b - bin LSB first, one bit per clock.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int            CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t            state;
    logic [WIDTH-1:0]  a_sr;
    logic [WIDTH-1:0]  b_sr;
    logic              br;
    logic [CW-1:0]     cnt;
    logic              cell_d;
    logic              cell_b;

    full_subtractor u_cell (
        .x    (a_sr[0]),
        .y    (b_sr[0]),
        .bin  (br),
        .d    (cell_d),
        .bout (cell_b)
    );

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);

    // diff/bout only move in S_BUSY so the last result survives in S_IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            a_sr  <= '0;
            b_sr  <= '0;
            br    <= 1'b0;
            cnt   <= '0;
            diff  <= '0;
            bout  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf   <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        br    <= bin;
                        cnt   <= '0;
                        state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    a_sr <= a_sr >> 1;
                    b_sr <= b_sr >> 1;
                    diff <= {cell_d, diff[WIDTH-1:1]};
                    br   <= cell_b;
                    bout <= cell_b;
                    cnt  <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        state <= S_DONE;
`ifdef SERIAL_SUB_OVF_EN
                        // br here is the borrow into the MSB cell
                        ovf   <= br ^ cell_b;
`endif
                    end
                end
                S_DONE: begin
                    if (out_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH=4).
module tb_serial_subtractor;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf;
`endif

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int acc_times[$];

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_n && in_valid && in_ready) acc_times.push_back(cyc);
    end

    task automatic start_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic bi);
        a        = av;
        b        = bv;
        bin      = bi;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic finish_op();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic do_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic bi,
                         output int lat, output logic [WIDTH-1:0] d, output logic bo);
        start_op(av, bv, bi);
        wait_done(lat);
        d  = diff;
        bo = bout;
        finish_op();
    endtask

    task automatic test_reset();
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a = '0; b = '0; bin = 1'b0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++;
        if (diff !== 4'h0 || bout !== 1'b0) begin
            errors++; $display("FAIL reset_outputs got diff=%h bout=%b exp diff=0 bout=0", diff, bout);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_arith();
        logic [WIDTH-1:0] vec_a [5] = '{4'd9, 4'd3, 4'd0, 4'd15, 4'd0};
        logic [WIDTH-1:0] vec_b [5] = '{4'd3, 4'd9, 4'd0, 4'd0,  4'd15};
        logic             vec_i [5] = '{1'b0, 1'b0, 1'b1, 1'b1,  1'b1};
        logic [WIDTH-1:0] exp_d [5] = '{4'd6, 4'hA, 4'hF, 4'hE,  4'h0};
        logic             exp_b [5] = '{1'b0, 1'b1, 1'b1, 1'b0,  1'b1};
        int               lat;
        logic [WIDTH-1:0] d;
        logic             bo;
        for (int i = 0; i < 5; i++) begin
            do_op(vec_a[i], vec_b[i], vec_i[i], lat, d, bo);
            checks++;
            if (lat !== WIDTH) begin errors++; $display("FAIL arith%0d_latency got=%0d exp=%0d", i, lat, WIDTH); end
            checks++;
            if (d !== exp_d[i] || bo !== exp_b[i]) begin
                errors++;
                $display("FAIL arith%0d_result got diff=%h bout=%b exp diff=%h bout=%b", i, d, bo, exp_d[i], exp_b[i]);
            end
            checks++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL arith%0d_release got in_ready=%b out_valid=%b exp 1/0", i, in_ready, out_valid);
            end
        end
    endtask

    task automatic test_backpressure();
        int lat;
        start_op(4'd5, 4'd2, 1'b0);
        // stray operands offered while busy must be ignored
        a = 4'd15; b = 4'd0; bin = 1'b1; in_valid = 1'b1;
        wait_done(lat);
        checks++;
        if (lat !== WIDTH) begin errors++; $display("FAIL bp_latency got=%0d exp=%0d", lat, WIDTH); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || diff !== 4'd3 || bout !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d got ov=%b ir=%b diff=%h bout=%b exp 1/0/3/0", i, out_valid, in_ready, diff, bout);
            end
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL bp_release got ir=%b ov=%b exp 1/0", in_ready, out_valid);
        end
        repeat (WIDTH + 2) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || diff !== 4'd3) begin
            errors++; $display("FAIL bp_no_capture got ov=%b ir=%b diff=%h exp 0/1/3", out_valid, in_ready, diff);
        end
    endtask

    task automatic test_mid_reset();
        int               lat;
        logic [WIDTH-1:0] d;
        logic             bo;
        start_op(4'd12, 4'd5, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || diff !== 4'd0 || bout !== 1'b0) begin
            errors++;
            $display("FAIL midrst_state got ov=%b ir=%b diff=%h bout=%b exp 0/1/0/0", out_valid, in_ready, diff, bout);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_op(4'd12, 4'd5, 1'b0, lat, d, bo);
        checks++;
        if (lat !== WIDTH || d !== 4'd7 || bo !== 1'b0) begin
            errors++; $display("FAIL midrst_rerun got lat=%0d diff=%h bout=%b exp %0d/7/0", lat, d, bo, WIDTH);
        end
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] r_d [2];
        logic             r_b [2];
        int               n = 0;
        int               guard = 0;
        acc_times.delete();
        a = 4'd10; b = 4'd4; bin = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        while (n < 2 && guard < 40) begin
            @(negedge clk);
            guard++;
            if (out_valid) begin
                r_d[n] = diff;
                r_b[n] = bout;
                n++;
                a = 4'd6; b = 4'd9; bin = 1'b1;
            end
        end
        in_valid  = 1'b0;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (n !== 2) begin
            errors++; $display("FAIL b2b_count got=%0d exp=2", n);
        end else begin
            checks++;
            if (r_d[0] !== 4'd6 || r_b[0] !== 1'b0) begin
                errors++; $display("FAIL b2b_first got diff=%h bout=%b exp 6/0", r_d[0], r_b[0]);
            end
            checks++;
            if (r_d[1] !== 4'hC || r_b[1] !== 1'b1) begin
                errors++; $display("FAIL b2b_second got diff=%h bout=%b exp c/1", r_d[1], r_b[1]);
            end
        end
        checks++;
        if (acc_times.size() < 2) begin
            errors++; $display("FAIL b2b_gap got accepts=%0d exp>=2", acc_times.size());
        end else if (acc_times[1] - acc_times[0] !== WIDTH + 2) begin
            errors++; $display("FAIL b2b_gap got=%0d exp=%0d", acc_times[1] - acc_times[0], WIDTH + 2);
        end
    endtask

`ifdef SERIAL_SUB_OVF_EN
    task automatic test_ovf();
        logic [WIDTH-1:0] vec_a [3] = '{4'd8, 4'd7, 4'd7};
        logic [WIDTH-1:0] vec_b [3] = '{4'd1, 4'd1, 4'd8};
        logic [WIDTH-1:0] exp_d [3] = '{4'd7, 4'd6, 4'd15};
        logic             exp_b [3] = '{1'b0, 1'b0, 1'b1};
        logic             exp_o [3] = '{1'b1, 1'b0, 1'b1};
        int lat;
        for (int i = 0; i < 3; i++) begin
            start_op(vec_a[i], vec_b[i], 1'b0);
            wait_done(lat);
            checks++;
            if (out_valid !== 1'b1 || diff !== exp_d[i] || bout !== exp_b[i] || ovf !== exp_o[i]) begin
                errors++;
                $display("FAIL ovf%0d got ov=%b diff=%h bout=%b ovf=%b exp 1/%h/%b/%b",
                         i, out_valid, diff, bout, ovf, exp_d[i], exp_b[i], exp_o[i]);
            end
            finish_op();
        end
    endtask
`endif

    initial begin
        test_reset();
        test_arith();
        test_backpressure();
        test_mid_reset();
        test_back_to_back();
`ifdef SERIAL_SUB_OVF_EN
        test_ovf();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
